// File: rtl/silife_pkg.sv
// Shared constants and types for the silife display buffer.
package silife_pkg;

   localparam int unsigned SILIFE_COLS  = 32;
   localparam int unsigned SILIFE_ROWS  = 8;
   localparam int unsigned SILIFE_COL_W = $clog2(SILIFE_COLS);

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WAIT_IDLE = 2'd1,
      ST_REQUEST   = 2'd2
   } dispbuf_state_e;

endpackage

// File: rtl/silife_dispbuf_bank.sv
// 32x8 cell bank: one synchronous write port, one combinational read port,
// synchronous clear.
module silife_dispbuf_bank
   import silife_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [SILIFE_COL_W-1:0] wr_col,
   input  logic [SILIFE_ROWS-1:0]  wr_data,
   input  logic [SILIFE_COL_W-1:0] rd_col,
   output logic [SILIFE_ROWS-1:0]  rd_data
);

   logic [SILIFE_ROWS-1:0] mem_q [SILIFE_COLS];
   logic [SILIFE_ROWS-1:0] mem_d [SILIFE_COLS];

   // Next bank contents: the addressed column takes the write data.
   always_comb begin
      mem_d = mem_q;
      if (wr_en) begin
         mem_d[wr_col] = wr_data;
      end
   end

   // Bank storage with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_q <= '{default: '0};
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q[rd_col];

endmodule

// File: rtl/silife_display_buffer.sv
// Frame store feeding silife_max7219. Swaps front/back banks only while the
// driver is idle and holds the frame request as a level.
// Define SILIFE_DISPBUF_DOUBLE_EN for double buffering; without it a single
// shared bank is used and tearing is accepted.
module silife_display_buffer
   import silife_pkg::*;
#(
   parameter logic [23:0] REFRESH_CYCLES = 24'd1_000_000
)
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    i_wr_en,
   input  logic [SILIFE_COL_W-1:0] i_wr_col,
   input  logic [SILIFE_ROWS-1:0]  i_wr_data,
   input  logic                    i_commit,
   input  logic [SILIFE_COL_W-1:0] i_row_select,
   input  logic                    i_busy,
   output logic [SILIFE_ROWS-1:0]  o_cells,
   output logic                    o_frame,
   output logic                    o_commit_done
);

   localparam logic        REFRESH_EN = (REFRESH_CYCLES != 24'd0);
   localparam logic [23:0] RELOAD     = REFRESH_CYCLES - 24'd1;

   dispbuf_state_e state_q, state_d;
   logic           pending_q, pending_d;
   logic           commit_done_q, commit_done_d;
   logic [23:0]    timer_q, timer_d;

`ifdef SILIFE_DISPBUF_DOUBLE_EN
   logic                   bank_sel_q, bank_sel_d;
   logic [SILIFE_ROWS-1:0] rd0, rd1;

   // bank_sel names the front bank; writes go to the other one.
   silife_dispbuf_bank u_bank0 (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (i_wr_en & bank_sel_q),
      .wr_col  (i_wr_col),
      .wr_data (i_wr_data),
      .rd_col  (i_row_select),
      .rd_data (rd0)
   );

   silife_dispbuf_bank u_bank1 (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (i_wr_en & ~bank_sel_q),
      .wr_col  (i_wr_col),
      .wr_data (i_wr_data),
      .rd_col  (i_row_select),
      .rd_data (rd1)
   );

   assign o_cells = bank_sel_q ? rd1 : rd0;
`else
   silife_dispbuf_bank u_bank0 (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (i_wr_en),
      .wr_col  (i_wr_col),
      .wr_data (i_wr_data),
      .rd_col  (i_row_select),
      .rd_data (o_cells)
   );
`endif

   // Next-state, pending merge, refresh timer and swap decision.
   always_comb begin
      state_d       = state_q;
      pending_d     = pending_q | i_commit;
      commit_done_d = 1'b0;
      timer_d       = timer_q;
`ifdef SILIFE_DISPBUF_DOUBLE_EN
      bank_sel_d    = bank_sel_q;
`endif
      if (REFRESH_EN && timer_q != 24'd0) begin
         timer_d = timer_q - 24'd1;
      end

      unique case (state_q)
         ST_IDLE: begin
            // A same-cycle commit is honoured directly so WAIT_IDLE follows in one cycle.
            if (pending_q || i_commit) begin
               state_d = ST_WAIT_IDLE;
            end else if (REFRESH_EN && timer_q == 24'd0) begin
               state_d = ST_REQUEST;
               timer_d = RELOAD;
            end
         end
         ST_WAIT_IDLE: begin
            if (!i_busy) begin
`ifdef SILIFE_DISPBUF_DOUBLE_EN
               bank_sel_d = ~bank_sel_q;
`endif
               // A commit arriving on the swap cycle stays pending for the next pass.
               pending_d     = i_commit;
               commit_done_d = 1'b1;
               state_d       = ST_REQUEST;
               timer_d       = RELOAD;
            end
         end
         ST_REQUEST: begin
            if (i_busy) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         pending_q     <= 1'b0;
         commit_done_q <= 1'b0;
         timer_q       <= RELOAD;
`ifdef SILIFE_DISPBUF_DOUBLE_EN
         bank_sel_q    <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         pending_q     <= pending_d;
         commit_done_q <= commit_done_d;
         timer_q       <= timer_d;
`ifdef SILIFE_DISPBUF_DOUBLE_EN
         bank_sel_q    <= bank_sel_d;
`endif
      end
   end

   assign o_frame       = (state_q == ST_REQUEST);
   assign o_commit_done = commit_done_q;

endmodule
